// File: rtl/adbg_pkg.sv
// Shared constants, status record and ID-range helper for the advanced-debug top-level selector.
package adbg_pkg;

  localparam int ADBG_ID_WIDTH    = 5;
  localparam int ADBG_BCAST_ID    = 31;
  localparam int ADBG_SHIFT_WIDTH = 53;

  typedef struct packed {
    logic                     sel_err;
    logic                     bcast;
    logic [ADBG_ID_WIDTH-1:0] id;
  } adbg_top_status_t;

  function automatic logic adbg_id_valid(input int id, input int nb);
    return (id >= 0) && (id < nb);
  endfunction

endpackage

// File: rtl/adbg_sel_decode.sv
// Combinational decode of the module-ID register / broadcast flag into per-module selects and the TDO mux index.
module adbg_sel_decode
  import adbg_pkg::*;
#(
  parameter int NB_MODULES = 5,
  parameter int ID_WIDTH   = ADBG_ID_WIDTH,
  parameter int IDX_W      = 3
) (
  input  logic [ID_WIDTH-1:0]   id_i,
  input  logic                  bcast_i,
  output logic [NB_MODULES-1:0] module_select_o,
  output logic [IDX_W-1:0]      tdo_idx_o,
  output logic                  tdo_en_o
);

  always_comb begin
    module_select_o = '0;
    tdo_idx_o       = '0;
    tdo_en_o        = 1'b0;
    // Broadcast drives every CPU module; the first CPU answers on TDO.
    if (bcast_i) begin
      module_select_o = {{(NB_MODULES-1){1'b1}}, 1'b0};
      tdo_idx_o       = IDX_W'(1);
      tdo_en_o        = 1'b1;
    end else if (adbg_id_valid(32'(id_i), NB_MODULES)) begin
      module_select_o = NB_MODULES'(1) << id_i;
      tdo_idx_o       = IDX_W'(id_i);
      tdo_en_o        = 1'b1;
    end
  end

endmodule

// File: rtl/adbg_top_sel.sv
// Advanced-debug chain selector: DR shift register, module-ID/broadcast/error state, select decode and TDO mux.
// Optional feature macro ADBG_TOP_STATUS_EN: Capture-DR loads {sel_err, bcast, id} and clears sel_err.
module adbg_top_sel
  import adbg_pkg::*;
#(
  parameter int NB_MODULES  = 5,
  parameter int ID_WIDTH    = ADBG_ID_WIDTH,
  parameter int SHIFT_WIDTH = ADBG_SHIFT_WIDTH,
  parameter int BCAST_ID    = ADBG_BCAST_ID
) (
  input  logic                   tck_i,
  input  logic                   trstn_i,
  input  logic                   tdi_i,
  output logic                   tdo_o,
  input  logic                   shift_dr_i,
  input  logic                   capture_dr_i,
  input  logic                   update_dr_i,
  input  logic                   debug_select_i,
  output logic [SHIFT_WIDTH-1:0] data_register_o,
  output logic [NB_MODULES-1:0]  module_select_o,
  input  logic [NB_MODULES-1:0]  module_inhibit_i,
  input  logic [NB_MODULES-1:0]  module_tdo_i,
  output logic                   bcast_o,
  output logic [ID_WIDTH-1:0]    sel_id_o,
  output logic                   sel_err_o
);

  localparam int IDX_W = (NB_MODULES > 1) ? $clog2(NB_MODULES) : 1;

  if (((2 ** ID_WIDTH) <= NB_MODULES) || (BCAST_ID < NB_MODULES) ||
      (BCAST_ID >= (2 ** ID_WIDTH)) || (SHIFT_WIDTH < ID_WIDTH + 5)) begin : g_param_chk
    $error("adbg_top_sel: inconsistent NB_MODULES/ID_WIDTH/SHIFT_WIDTH/BCAST_ID");
  end

  logic [SHIFT_WIDTH-1:0] sr_q, sr_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic                   bcast_q, bcast_d;
  logic                   err_q, err_d;

  logic                   cmd;
  logic [ID_WIDTH-1:0]    id_in;
  logic                   inhibit;
  logic                   sel_upd;
  logic [IDX_W-1:0]       tdo_idx;
  logic                   tdo_en;

  assign cmd     = sr_q[SHIFT_WIDTH-1];
  assign id_in   = sr_q[SHIFT_WIDTH-2 -: ID_WIDTH];
  assign inhibit = |module_inhibit_i;
  assign sel_upd = debug_select_i & update_dr_i & cmd;

  always_comb begin
    sr_d    = sr_q;
    id_d    = id_q;
    bcast_d = bcast_q;
    err_d   = err_q;

    if (debug_select_i) begin
      if (capture_dr_i) begin
`ifdef ADBG_TOP_STATUS_EN
        sr_d  = SHIFT_WIDTH'({err_q, bcast_q, id_q});
        err_d = 1'b0;
`endif
      end else if (shift_dr_i) begin
        sr_d = {tdi_i, sr_q[SHIFT_WIDTH-1:1]};
      end
    end

    // Evaluated after the status clear so a rejection in the same cycle keeps the flag set.
    if (sel_upd) begin
      if (inhibit) begin
        err_d = 1'b1;
      end else if (id_in == ID_WIDTH'(BCAST_ID)) begin
        bcast_d = 1'b1;
        id_d    = id_in;
      end else begin
        bcast_d = 1'b0;
        id_d    = id_in;
        if (!adbg_id_valid(32'(id_in), NB_MODULES)) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      sr_q    <= '0;
      id_q    <= '0;
      bcast_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      id_q    <= id_d;
      bcast_q <= bcast_d;
      err_q   <= err_d;
    end
  end

  adbg_sel_decode #(
    .NB_MODULES(NB_MODULES),
    .ID_WIDTH  (ID_WIDTH),
    .IDX_W     (IDX_W)
  ) u_decode (
    .id_i           (id_q),
    .bcast_i        (bcast_q),
    .module_select_o(module_select_o),
    .tdo_idx_o      (tdo_idx),
    .tdo_en_o       (tdo_en)
  );

  assign tdo_o           = tdo_en & module_tdo_i[tdo_idx];
  assign data_register_o = sr_q;
  assign sel_id_o        = id_q;
  assign bcast_o         = bcast_q;
  assign sel_err_o       = err_q;

endmodule
